// File: rtl/fifo_controller_width_packing.sv
// rtl/fifo_controller_width_packing.sv - narrow-write, wide-read packing FIFO
// Accepts one DATA_WIDTH word per write, returns two packed words per read (show-ahead).
module fifo_controller_width_packing #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic                    write_i,
   input  logic [DATA_WIDTH-1:0]   write_data_i,
   input  logic                    read_i,
   output logic [2*DATA_WIDTH-1:0] read_data_o,
   output logic [ADDR_WIDTH-1:0]   write_address_o,
   output logic [ADDR_WIDTH-1:0]   read_address_1_o,
   output logic [ADDR_WIDTH-1:0]   read_address_2_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [ADDR_WIDTH:0]     level_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wptr, rptr;
   logic [ADDR_WIDTH:0]   wptr_nxt, rptr_nxt, level_nxt;
   logic                  write_accept, read_accept;

   always_comb begin
      write_accept = write_i && !full_o;
      read_accept  = read_i && !empty_o;
      wptr_nxt     = write_accept ? wptr + (ADDR_WIDTH+1)'(1) : wptr;
      rptr_nxt     = read_accept  ? rptr + (ADDR_WIDTH+1)'(2) : rptr;
      level_nxt    = wptr_nxt - rptr_nxt;
   end

   // Level never exceeds DEPTH, so its MSB alone marks full and the upper bits mark < 2.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wptr    <= '0;
         rptr    <= '0;
         level_o <= '0;
         full_o  <= 1'b0;
         empty_o <= 1'b1;
      end else begin
         wptr    <= wptr_nxt;
         rptr    <= rptr_nxt;
         level_o <= level_nxt;
         full_o  <= level_nxt[ADDR_WIDTH];
         empty_o <= (level_nxt[ADDR_WIDTH:1] == '0);
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk_i) begin
      if (write_accept) begin
         mem[write_address_o] <= write_data_i;
      end
   end

   always_comb begin
      write_address_o  = wptr[ADDR_WIDTH-1:0];
      read_address_1_o = rptr[ADDR_WIDTH-1:0];
      read_address_2_o = read_address_1_o + ADDR_WIDTH'(1);
      read_data_o      = {mem[read_address_2_o], mem[read_address_1_o]};
   end

endmodule

// File: doc/fifo_controller_width_packing.md
# fifo_controller_width_packing

Synchronous FIFO that accepts one narrow word per write and delivers two narrow words, packed as one wide word, per read. It is the read-side counterpart of our narrow-read width-conversion FIFO and feeds wide-word consumers from narrow-word producers. The block holds word-granular write/read pointers, full/empty/level status, and a register-file store with show-ahead wide read data.

## Interface
- ADDR_WIDTH, 4, word address width; DEPTH = 2**ADDR_WIDTH narrow words, ADDR_WIDTH >= 1
- DATA_WIDTH, 8, narrow word width; wide word = 2*DATA_WIDTH

- clk_i  input  1  clock, all state updates on rising edge
- reset_ni  input  1  asynchronous, active-low reset
- write_i  input  1  push one narrow word this cycle
- write_data_i  input  DATA_WIDTH  narrow word to push
- read_i  input  1  pop one wide word (two narrow words) this cycle
- read_data_o  output  2*DATA_WIDTH  {mem[read_address_2_o], mem[read_address_1_o]}, show-ahead
- write_address_o  output  ADDR_WIDTH  next narrow write location
- read_address_1_o  output  ADDR_WIDTH  low-half read location (always even)
- read_address_2_o  output  ADDR_WIDTH  high-half read location = read_address_1_o + 1
- full_o  output  1  level == DEPTH
- empty_o  output  1  level < 2 (no complete wide word available)
- level_o  output  ADDR_WIDTH+1  narrow words stored, 0..DEPTH

## Operation
- Pointers wptr, rptr are ADDR_WIDTH+1 bits; addresses are their low ADDR_WIDTH bits; level = wptr - rptr (modulo 2**(ADDR_WIDTH+1)).
- Write accepted iff write_i && !full_o: mem[write_address_o] <= write_data_i, wptr += 1.
- Read accepted iff read_i && !empty_o: rptr += 2.
- rptr starts at 0 and moves by 2, so read_address_1_o is always even and the pair never straddles the wrap point.
- Both accepted same cycle: level changes by -1. Acceptance uses flags valid before the edge; a write while full is dropped even if a read is also accepted that cycle.
- Rejected requests have no effect on any state; no error output.
- Odd residue: a single leftover narrow word stays stored with empty_o = 1 until a further write completes the pair.
- Little-endian packing: the earlier-written word is the low half of read_data_o.
- Memory contents are not reset; read_data_o is undefined while empty_o = 1.

## Timing
- Reset (reset_ni low, asynchronous, no clock needed): wptr = rptr = 0; write_address_o = 0, read_address_1_o = 0, read_address_2_o = 1, level_o = 0, empty_o = 1, full_o = 0. Release is synchronous to the next clock edge.
- Pointers, level_o, full_o, empty_o are registered; they update on the edge that accepts the request.
- read_data_o is combinational from memory and read addresses: valid the same cycle empty_o deasserts; a word written on an edge is readable from the following cycle (no write-through).
- Read latency 0 (show-ahead); throughput one narrow write and one wide read per cycle.
- Wrap-around: write_address_o wraps DEPTH-1 -> 0; read_address_1_o wraps DEPTH-2 -> 0; the extra pointer bit disambiguates full vs. zero.
- Reset asserted mid-operation discards all stored data; outputs take reset values immediately, without waiting for a clock edge.

## Test plan
- Reset: hold reset_ni = 0 for 2 cycles -> level_o = 0, empty_o = 1, full_o = 0, read addresses 0/1, write_address_o = 0.
- Pack: write 0x11 then 0x22 -> after first edge level_o = 1, empty_o = 1; after second edge empty_o = 0 and read_data_o = 0x2211; one read -> level_o = 0, read_address_1_o = 2.
- Fill/overflow/drain (ADDR_WIDTH = 4, DATA_WIDTH = 8): write 0x00..0x0F -> full_o = 1, level_o = 16; write 0xFF -> dropped, level_o stays 16; 8 reads -> 0x0100, 0x0302, ..., 0x0F0E, then empty_o = 1; a 9th read has no effect.
- Odd residue: write 3 words, hold read_i for 3 cycles -> exactly one pop, level_o = 1, empty_o = 1; one more write -> empty_o = 0 and read_data_o = {word4, word3}.
- Simultaneous + wrap: at level 2 assert write_i and read_i -> level_o = 1; when full, write_i and read_i together -> write dropped, level_o = 14; stream for 40 cycles with 1 write/cycle and a read every 2nd cycle -> addresses wrap and every wide word matches the model.
- Async reset mid-op: at level 5, pull reset_ni low between clock edges -> level_o = 0 and empty_o = 1 before the next edge; after release, a write of 0xAA lands at address 0.
